// File: rtl/wdt_pkg.sv
// wdt_pkg
// Shared types and constants for the watchdog timer.
//   wdt_state_e  : FSM state encoding (IDLE, ARMED, TIMEOUT)
//   WDT_A_*      : register-port addresses
package wdt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TIMEOUT = 2'd2
    } wdt_state_e;

    localparam logic [1:0] WDT_A_WDEN   = 2'd0;
    localparam logic [1:0] WDT_A_WDLIVE = 2'd1;
    localparam logic [1:0] WDT_A_WTOCNT = 2'd2;
    localparam logic [1:0] WDT_A_WDCNT  = 2'd3;

endpackage

// File: rtl/wdt_timer_prescaler.sv
// wdt_prescaler
// Divides the clock into a one-cycle tick every PRESCALE enabled cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the phase counter (wins over en)
//   en         : count enable; the counter holds while low
//   tick       : one-cycle pulse on the enabled cycle that wraps the counter
module wdt_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    if (PRESCALE <= 1) begin : g_pass
        // No division: every enabled cycle is a tick.
        logic unused_pass;
        assign unused_pass = clk ^ rst_n ^ clr;
        assign tick        = en;
    end else begin : g_div
        localparam int PW = $clog2(PRESCALE);

        logic [PW-1:0] pcnt_q;
        logic          last;

        assign last = (pcnt_q == PW'(PRESCALE - 1));
        assign tick = en && last;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pcnt_q <= '0;
            end else if (clr) begin
                pcnt_q <= '0;
            end else if (en) begin
                pcnt_q <= last ? '0 : pcnt_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/wdt_timer.sv
// wdt_timer
// Watchdog timer with a small register port. Raises a level timeout once the
// tick count reaches the programmed threshold; cleared by a kick or disable.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wdt_we     : register write strobe
//   wdt_addr   : 0 WDEN, 1 WDLIVE (write-only), 2 WTOCNT, 3 WDCNT (read-only)
//   wdt_wdata  : write data
//   wdt_rdata  : combinational read of wdt_addr
//   wto        : registered timeout level
//
// state   | meaning
// IDLE    | disabled; count and prescaler held at 0, wto=0
// ARMED   | counting ticks toward WTOCNT
// TIMEOUT | threshold reached; wto=1, count and prescaler hold
module wdt_timer
    import wdt_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wdt_we,
    input  logic [1:0]  wdt_addr,
    input  logic [31:0] wdt_wdata,
    output logic [31:0] wdt_rdata,
    output logic        wto
);

    wdt_state_e       state_q;
    logic             wden_q;
    logic [CNT_W-1:0] wtocnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wto_q;

    logic [CNT_W-1:0] wdata_cnt;
    logic [31:0]      wtocnt_rd;
    logic [31:0]      cnt_rd;

    if (CNT_W >= 32) begin : g_wide
        assign wdata_cnt = CNT_W'(wdt_wdata);
        assign wtocnt_rd = wtocnt_q[31:0];
        assign cnt_rd    = cnt_q[31:0];
    end else begin : g_narrow
        assign wdata_cnt = wdt_wdata[CNT_W-1:0];
        assign wtocnt_rd = {{(32-CNT_W){1'b0}}, wtocnt_q};
        assign cnt_rd    = {{(32-CNT_W){1'b0}}, cnt_q};
    end

    logic wr_wden, wr_wtocnt, disable_wr, enable_wr, kick;
    logic active;
    logic tick;

    assign active     = (state_q != IDLE);
    assign wr_wden    = wdt_we && (wdt_addr == WDT_A_WDEN);
    assign wr_wtocnt  = wdt_we && (wdt_addr == WDT_A_WTOCNT);
    assign disable_wr = wr_wden && !wdt_wdata[0];
    assign enable_wr  = wr_wden &&  wdt_wdata[0];
    assign kick       = wdt_we && (wdt_addr == WDT_A_WDLIVE) && wdt_wdata[0] && active;

    // Saturating increment.
    assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // The prescaler only advances while ARMED, so it holds in TIMEOUT.
    wdt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!active || kick || disable_wr),
        .en    (state_q == ARMED),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wden_q   <= 1'b0;
            wtocnt_q <= '1;
            cnt_q    <= '0;
            wto_q    <= 1'b0;
        end else begin
            if (wr_wden)   wden_q   <= wdt_wdata[0];
            if (wr_wtocnt) wtocnt_q <= wdata_cnt;

            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    wto_q <= 1'b0;
                    if (enable_wr) state_q <= ARMED;
                end
                ARMED, TIMEOUT: begin
                    if (disable_wr) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        wto_q   <= 1'b0;
                    end else if (kick) begin
                        state_q <= ARMED;
                        cnt_q   <= '0;
                        wto_q   <= 1'b0;
                    end else if (state_q == ARMED && tick) begin
                        cnt_q <= cnt_d;
                        if (cnt_d >= wtocnt_q) begin
                            state_q <= TIMEOUT;
                            wto_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    wto_q   <= 1'b0;
                end
            endcase
        end
    end

    assign wto = wto_q;

    always_comb begin
        wdt_rdata = 32'd0;
        unique case (wdt_addr)
            WDT_A_WDEN:   wdt_rdata = {31'd0, wden_q};
            WDT_A_WDLIVE: wdt_rdata = 32'd0;
            WDT_A_WTOCNT: wdt_rdata = wtocnt_rd;
            WDT_A_WDCNT:  wdt_rdata = cnt_rd;
            default:      wdt_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_wdt_timer.sv
// tb_wdt_timer
// Directed bench for wdt_timer: one instance with PRESCALE=1, one with
// PRESCALE=4, sharing clock, reset, address and write data.
module tb_wdt_timer;
    import wdt_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        we1, we4;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata4;
    logic        wto1, wto4;

    int n_chk = 0;
    int n_err = 0;

    wdt_timer #(.CNT_W(32), .PRESCALE(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wdt_we    (we1),
        .wdt_addr  (addr),
        .wdt_wdata (wdata),
        .wdt_rdata (rdata1),
        .wto       (wto1)
    );

    wdt_timer #(.CNT_W(32), .PRESCALE(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wdt_we    (we4),
        .wdt_addr  (addr),
        .wdt_wdata (wdata),
        .wdt_rdata (rdata4),
        .wto       (wto4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write one register; returns 1 time unit after the sampling edge.
    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        addr  = a;
        wdata = v;
        we1   = (d == 1);
        we4   = (d == 4);
        @(posedge clk);
        #1;
        we1 = 1'b0;
        we4 = 1'b0;
    endtask

    task automatic rd(input int d, input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = (d == 1) ? rdata1 : rdata4;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] v;
        rst_n = 1'b0;
        we1   = 1'b0;
        we4   = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;

        // Reset state
        #12;
        chk("rst_wto1", {31'd0, wto1}, 32'd0);
        chk("rst_wto4", {31'd0, wto4}, 32'd0);
        rd(1, WDT_A_WDEN, v);   chk("rst_wden", v, 32'd0);
        rd(1, WDT_A_WTOCNT, v); chk("rst_wtocnt", v, 32'hFFFF_FFFF);
        rd(1, WDT_A_WDCNT, v);  chk("rst_wdcnt", v, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // PRESCALE=1: threshold 5
        wr(1, WDT_A_WTOCNT, 32'd5);
        rd(1, WDT_A_WTOCNT, v); chk("p1_wtocnt_rd", v, 32'd5);
        wr(1, WDT_A_WDEN, 32'd1);
        rd(1, WDT_A_WDCNT, v); chk("p1_cnt_e0", v, 32'd0);
        chk("p1_wto_e0", {31'd0, wto1}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            rd(1, WDT_A_WDCNT, v); chk($sformatf("p1_cnt_e%0d", k), v, k);
            chk($sformatf("p1_wto_e%0d", k), {31'd0, wto1}, (k == 5) ? 32'd1 : 32'd0);
        end
        step(3);
        rd(1, WDT_A_WDCNT, v); chk("p1_cnt_hold", v, 32'd5);
        chk("p1_wto_hold", {31'd0, wto1}, 32'd1);

        // Kick in TIMEOUT
        wr(1, WDT_A_WDLIVE, 32'd1);
        chk("p1_kick_wto", {31'd0, wto1}, 32'd0);
        rd(1, WDT_A_WDCNT, v); chk("p1_kick_cnt", v, 32'd0);
        rd(1, WDT_A_WDLIVE, v); chk("p1_wdlive_rd", v, 32'd0);

        // Kick on the edge that would reach the threshold
        step(4);
        rd(1, WDT_A_WDCNT, v); chk("p1_pre_kick_cnt", v, 32'd4);
        wr(1, WDT_A_WDLIVE, 32'd1);
        chk("p1_race_wto", {31'd0, wto1}, 32'd0);
        rd(1, WDT_A_WDCNT, v); chk("p1_race_cnt", v, 32'd0);
        step(2);
        rd(1, WDT_A_WDCNT, v); chk("p1_resume_cnt", v, 32'd2);
        chk("p1_resume_wto", {31'd0, wto1}, 32'd0);

        // Reach TIMEOUT again, then disable
        step(3);
        chk("p1_to2_wto", {31'd0, wto1}, 32'd1);
        wr(1, WDT_A_WDEN, 32'd0);
        chk("p1_dis_wto", {31'd0, wto1}, 32'd0);
        rd(1, WDT_A_WDCNT, v); chk("p1_dis_cnt", v, 32'd0);
        rd(1, WDT_A_WDEN, v);  chk("p1_dis_wden", v, 32'd0);
        step(5);
        rd(1, WDT_A_WDCNT, v); chk("p1_idle_cnt", v, 32'd0);
        chk("p1_idle_wto", {31'd0, wto1}, 32'd0);

        // Kick in IDLE has no effect
        wr(1, WDT_A_WDLIVE, 32'd1);
        step(3);
        rd(1, WDT_A_WDCNT, v); chk("p1_idle_kick_cnt", v, 32'd0);
        chk("p1_idle_kick_wto", {31'd0, wto1}, 32'd0);

        // WTOCNT=0 times out on the first tick
        wr(1, WDT_A_WTOCNT, 32'd0);
        wr(1, WDT_A_WDEN, 32'd1);
        chk("p1_z_wto_e0", {31'd0, wto1}, 32'd0);
        step(1);
        chk("p1_z_wto_e1", {31'd0, wto1}, 32'd1);
        rd(1, WDT_A_WDCNT, v); chk("p1_z_cnt_e1", v, 32'd1);

        // WDEN=1 in TIMEOUT has no effect
        wr(1, WDT_A_WDEN, 32'd1);
        step(2);
        chk("p1_reen_wto", {31'd0, wto1}, 32'd1);
        rd(1, WDT_A_WDCNT, v); chk("p1_reen_cnt", v, 32'd1);

        // Asynchronous reset while in TIMEOUT
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wto", {31'd0, wto1}, 32'd0);
        rd(1, WDT_A_WDCNT, v);  chk("arst_cnt", v, 32'd0);
        rd(1, WDT_A_WTOCNT, v); chk("arst_wtocnt", v, 32'hFFFF_FFFF);
        #1;
        rst_n = 1'b1;
        step(5);
        rd(1, WDT_A_WDCNT, v); chk("arst_idle_cnt", v, 32'd0);
        rd(1, WDT_A_WDEN, v);  chk("arst_idle_wden", v, 32'd0);
        chk("arst_idle_wto", {31'd0, wto1}, 32'd0);

        // PRESCALE=4: threshold 3 -> timeout 12 edges after enable
        wr(4, WDT_A_WTOCNT, 32'd3);
        wr(4, WDT_A_WDEN, 32'd1);
        step(3);
        rd(4, WDT_A_WDCNT, v); chk("p4_cnt_e3", v, 32'd0);
        step(1);
        rd(4, WDT_A_WDCNT, v); chk("p4_cnt_e4", v, 32'd1);
        step(4);
        rd(4, WDT_A_WDCNT, v); chk("p4_cnt_e8", v, 32'd2);
        step(3);
        chk("p4_wto_e11", {31'd0, wto4}, 32'd0);
        step(1);
        chk("p4_wto_e12", {31'd0, wto4}, 32'd1);
        rd(4, WDT_A_WDCNT, v); chk("p4_cnt_e12", v, 32'd3);

        // Lowering WTOCNT below WDCNT while ARMED
        wr(4, WDT_A_WTOCNT, 32'd100);
        wr(4, WDT_A_WDLIVE, 32'd1);
        chk("p4_kick_wto", {31'd0, wto4}, 32'd0);
        step(28);
        rd(4, WDT_A_WDCNT, v); chk("p4_cnt_k28", v, 32'd7);
        chk("p4_wto_k28", {31'd0, wto4}, 32'd0);
        wr(4, WDT_A_WTOCNT, 32'd2);
        rd(4, WDT_A_WTOCNT, v); chk("p4_low_rd", v, 32'd2);
        chk("p4_low_wto_k29", {31'd0, wto4}, 32'd0);
        step(2);
        chk("p4_low_wto_k31", {31'd0, wto4}, 32'd0);
        step(1);
        chk("p4_low_wto_k32", {31'd0, wto4}, 32'd1);
        rd(4, WDT_A_WDCNT, v); chk("p4_low_cnt_k32", v, 32'd8);

        // WDCNT is read-only
        wr(4, WDT_A_WDCNT, 32'd5);
        rd(4, WDT_A_WDCNT, v); chk("p4_wdcnt_ro", v, 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
